// File: rtl/mac_arb_pkg.sv
// Shared types and widths for the MAC stream arbiter.
package mac_arb_pkg;

  localparam int unsigned TID_W = 8;   // AXIS TID width on the MAC side
  localparam int unsigned CNT_W = 4;   // per-requester outstanding counter width
  localparam int unsigned RES_W = 32;  // MAC result width

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   last      : index granted most recently (highest priority goes to last+1)
//   grant     : chosen index (valid when any_grant)
//   any_grant : at least one request present
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             any_grant
);

  // Scan from the farthest position back to last+1 so the nearest request wins.
  always_comb begin
    int idx;
    grant     = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = int'(N); k >= 1; k--) begin
      idx = (int'(last) + k) % int'(N);
      if (req[IDX_W'(idx)]) begin
        grant     = IDX_W'(idx);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_stream_arbiter.sv
// Shares one staged MAC between C_NUM_REQ operand streams. Packets are
// granted whole, round-robin, with one arbitration bubble each; the granted
// stream passes straight through tagged with its index in TID. Results are
// steered back by TID, and each requester is throttled by a count of packets
// issued but not yet answered.
//   S_AXIS_*  : packed per-requester operand streams (slice i = requester i)
//   MD_AXIS_* : operand stream to the MAC, TID = requester index
//   MI_AXIS_* : result stream from the MAC
//   R_AXIS_*  : results to requesters, data broadcast, valid/last one-hot
//   ERR_BAD_TID : sticky, set when a result handshakes with TID >= C_NUM_REQ
module mac_stream_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH      = 8,
  parameter int unsigned C_NUM_REQ         = 4,
  parameter int unsigned C_MAX_OUTSTANDING = 2
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_NUM_REQ*2*C_DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic [C_NUM_REQ-1:0]                 S_AXIS_TVALID,
  input  logic [C_NUM_REQ-1:0]                 S_AXIS_TLAST,
  input  logic [C_NUM_REQ-1:0]                 S_AXIS_TUSER,
  output logic [C_NUM_REQ-1:0]                 S_AXIS_TREADY,
  output logic [2*C_DATA_WIDTH-1:0]            MD_AXIS_TDATA,
  output logic                                 MD_AXIS_TVALID,
  output logic                                 MD_AXIS_TLAST,
  output logic                                 MD_AXIS_TUSER,
  output logic [TID_W-1:0]                     MD_AXIS_TID,
  input  logic                                 MD_AXIS_TREADY,
  input  logic [RES_W-1:0]                     MI_AXIS_TDATA,
  input  logic                                 MI_AXIS_TVALID,
  input  logic                                 MI_AXIS_TLAST,
  input  logic [TID_W-1:0]                     MI_AXIS_TID,
  output logic                                 MI_AXIS_TREADY,
  output logic [RES_W-1:0]                     R_AXIS_TDATA,
  output logic [C_NUM_REQ-1:0]                 R_AXIS_TVALID,
  output logic [C_NUM_REQ-1:0]                 R_AXIS_TLAST,
  input  logic [C_NUM_REQ-1:0]                 R_AXIS_TREADY,
  output logic                                 ERR_BAD_TID
);

  localparam int unsigned BEAT_W = 2 * C_DATA_WIDTH;
  localparam int unsigned IDX_W  = $clog2(C_NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_MAX_OUTSTANDING);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, last_q, arb_grant;
  logic                 arb_any;
  logic [CNT_W-1:0]     cnt_q [C_NUM_REQ];
  logic                 err_q;
  logic [C_NUM_REQ-1:0] eligible, inc, dec;
  logic                 md_last_hs, mi_hs, tid_ok;
  logic [IDX_W-1:0]     tid_idx;

  // A requester may compete only while under its outstanding limit.
  always_comb begin
    for (int i = 0; i < int'(C_NUM_REQ); i++) begin
      eligible[i] = S_AXIS_TVALID[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  rr_arbiter #(
    .N     (C_NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .last      (last_q),
    .grant     (arb_grant),
    .any_grant (arb_any)
  );

  // Next state and operand pass-through of the granted requester.
  always_comb begin
    state_d        = state_q;
    MD_AXIS_TDATA  = '0;
    MD_AXIS_TVALID = 1'b0;
    MD_AXIS_TLAST  = 1'b0;
    MD_AXIS_TUSER  = 1'b0;
    MD_AXIS_TID    = '0;
    S_AXIS_TREADY  = '0;
    md_last_hs     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) state_d = BUSY;
      end
      BUSY: begin
        MD_AXIS_TDATA          = S_AXIS_TDATA[int'(grant_q)*BEAT_W +: BEAT_W];
        MD_AXIS_TVALID         = S_AXIS_TVALID[grant_q];
        MD_AXIS_TLAST          = S_AXIS_TLAST[grant_q];
        MD_AXIS_TUSER          = S_AXIS_TUSER[grant_q];
        MD_AXIS_TID            = TID_W'(grant_q);
        S_AXIS_TREADY[grant_q] = MD_AXIS_TREADY;
        md_last_hs             = S_AXIS_TVALID[grant_q] && MD_AXIS_TREADY && S_AXIS_TLAST[grant_q];
        if (md_last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tid_ok  = MI_AXIS_TID < TID_W'(C_NUM_REQ);
  assign tid_idx = MI_AXIS_TID[IDX_W-1:0];

  // Result steering; unknown tags are accepted and dropped so the MAC never stalls.
  always_comb begin
    R_AXIS_TVALID  = '0;
    R_AXIS_TLAST   = '0;
    MI_AXIS_TREADY = 1'b1;
    if (tid_ok) begin
      R_AXIS_TVALID[tid_idx] = MI_AXIS_TVALID;
      R_AXIS_TLAST[tid_idx]  = MI_AXIS_TLAST;
      MI_AXIS_TREADY         = R_AXIS_TREADY[tid_idx];
    end
  end

  assign R_AXIS_TDATA = MI_AXIS_TDATA;
  assign mi_hs        = MI_AXIS_TVALID && MI_AXIS_TREADY;
  assign ERR_BAD_TID  = err_q;

  // Packet issued / result returned strobes per requester.
  always_comb begin
    for (int i = 0; i < int'(C_NUM_REQ); i++) begin
      inc[i] = md_last_hs && (grant_q == IDX_W'(i));
      dec[i] = mi_hs && MI_AXIS_TLAST && tid_ok && (tid_idx == IDX_W'(i));
    end
  end

  // State, grant, rotation pointer, counters and sticky error.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(C_NUM_REQ - 1);
      err_q   <= 1'b0;
      for (int i = 0; i < int'(C_NUM_REQ); i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && arb_any) grant_q <= arb_grant;
      if (md_last_hs) last_q <= grant_q;
      if (mi_hs && !tid_ok) err_q <= 1'b1;
      for (int i = 0; i < int'(C_NUM_REQ); i++) begin
        if (inc[i] && !dec[i] && (cnt_q[i] < CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_stream_arbiter.sv
// Self-checking bench for mac_stream_arbiter: directed scenarios followed by
// randomized traffic, all checked each cycle against a reference model of
// packet ownership and outstanding counts.
module tb_mac_stream_arbiter;
  import mac_arb_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned N    = 4;
  localparam int unsigned MAXO = 2;
  localparam int unsigned BW   = 2 * DW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic            ACLK;
  logic            ARESETN;
  logic [N*BW-1:0] S_AXIS_TDATA;
  logic [N-1:0]    S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TREADY;
  logic [BW-1:0]   MD_AXIS_TDATA;
  logic            MD_AXIS_TVALID, MD_AXIS_TLAST, MD_AXIS_TUSER, MD_AXIS_TREADY;
  logic [7:0]      MD_AXIS_TID;
  logic [31:0]     MI_AXIS_TDATA;
  logic            MI_AXIS_TVALID, MI_AXIS_TLAST, MI_AXIS_TREADY;
  logic [7:0]      MI_AXIS_TID;
  logic [31:0]     R_AXIS_TDATA;
  logic [N-1:0]    R_AXIS_TVALID, R_AXIS_TLAST, R_AXIS_TREADY;
  logic            ERR_BAD_TID;

  mac_stream_arbiter #(
    .C_DATA_WIDTH      (DW),
    .C_NUM_REQ         (N),
    .C_MAX_OUTSTANDING (MAXO)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TUSER   (S_AXIS_TUSER),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .MD_AXIS_TDATA  (MD_AXIS_TDATA),
    .MD_AXIS_TVALID (MD_AXIS_TVALID),
    .MD_AXIS_TLAST  (MD_AXIS_TLAST),
    .MD_AXIS_TUSER  (MD_AXIS_TUSER),
    .MD_AXIS_TID    (MD_AXIS_TID),
    .MD_AXIS_TREADY (MD_AXIS_TREADY),
    .MI_AXIS_TDATA  (MI_AXIS_TDATA),
    .MI_AXIS_TVALID (MI_AXIS_TVALID),
    .MI_AXIS_TLAST  (MI_AXIS_TLAST),
    .MI_AXIS_TID    (MI_AXIS_TID),
    .MI_AXIS_TREADY (MI_AXIS_TREADY),
    .R_AXIS_TDATA   (R_AXIS_TDATA),
    .R_AXIS_TVALID  (R_AXIS_TVALID),
    .R_AXIS_TLAST   (R_AXIS_TLAST),
    .R_AXIS_TREADY  (R_AXIS_TREADY),
    .ERR_BAD_TID    (ERR_BAD_TID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus state: per-requester beat queues, head is the presented beat.
  beat_t srcq [N][$];
  bit    rnd = 1'b0;
  bit    hs_s [N];
  bit    hs_mi;

  // Reference model: who owns the MAC (-1 = nobody), rotation pointer, counts.
  int m_own, m_last;
  int m_cnt [N];
  bit m_err;

  // Observation logs taken from the DUT outputs.
  int cyc = 0;
  int dut_beats = 0;
  int tid_log[$];
  int tlast_cyc[$];
  int hs_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_last = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_err  = 1'b0;
  endtask

  task automatic push_beat(input int i, input logic [BW-1:0] d, input bit last);
    beat_t b;
    b.data = d;
    b.last = last;
    b.user = 1'($urandom);
    srcq[i].push_back(b);
  endtask

  task automatic push_pkt(input int i, input int len);
    for (int k = 0; k < len; k++) push_beat(i, BW'($urandom), (k == len - 1));
  endtask

  // One clock: compare outputs against the model at the falling edge, then advance the model.
  task automatic step();
    logic [BW-1:0] e_data;
    logic [N-1:0]  e_srdy, e_rv, e_rl;
    bit            e_v, e_l, e_u, e_mrdy, tid_ok, set_err;
    int            tid, nxt_own, pick;
    int            inc [N];
    int            dec [N];
    @(negedge ACLK);
    cyc++;
    e_v = 1'b0; e_l = 1'b0; e_u = 1'b0; e_data = '0; e_srdy = '0;
    if (m_own >= 0) begin
      e_v            = S_AXIS_TVALID[m_own];
      e_l            = S_AXIS_TLAST[m_own];
      e_u            = S_AXIS_TUSER[m_own];
      e_data         = S_AXIS_TDATA[m_own*BW +: BW];
      e_srdy[m_own]  = MD_AXIS_TREADY;
    end
    tid    = int'(MI_AXIS_TID);
    tid_ok = (tid < N);
    e_rv = '0; e_rl = '0; e_mrdy = 1'b1;
    if (tid_ok) begin
      e_rv[tid] = MI_AXIS_TVALID;
      e_rl[tid] = MI_AXIS_TLAST;
      e_mrdy    = R_AXIS_TREADY[tid];
    end
    check_eq("md_valid", MD_AXIS_TVALID, e_v);
    if (e_v) begin
      check_eq("md_data", MD_AXIS_TDATA, e_data);
      check_eq("md_last", MD_AXIS_TLAST, e_l);
      check_eq("md_user", MD_AXIS_TUSER, e_u);
      check_eq("md_tid", MD_AXIS_TID, 64'(m_own));
    end
    check_eq("s_ready", S_AXIS_TREADY, e_srdy);
    check_eq("r_valid", R_AXIS_TVALID, e_rv);
    check_eq("r_last", R_AXIS_TLAST, e_rl);
    check_eq("r_data", R_AXIS_TDATA, MI_AXIS_TDATA);
    check_eq("mi_ready", MI_AXIS_TREADY, e_mrdy);
    check_eq("err_bad_tid", ERR_BAD_TID, m_err);

    if (MD_AXIS_TVALID && MD_AXIS_TREADY) begin
      dut_beats++;
      hs_cyc.push_back(cyc);
      if (MD_AXIS_TLAST) begin
        tid_log.push_back(int'(MD_AXIS_TID));
        tlast_cyc.push_back(cyc);
      end
    end

    for (int i = 0; i < N; i++) begin
      hs_s[i] = 1'b0; inc[i] = 0; dec[i] = 0;
    end
    nxt_own = m_own;
    if (m_own < 0) begin
      for (int k = 1; k <= N; k++) begin
        pick = (m_last + k) % N;
        if (S_AXIS_TVALID[pick] && m_cnt[pick] < int'(MAXO)) begin
          nxt_own = pick;
          break;
        end
      end
    end else if (e_v && MD_AXIS_TREADY) begin
      hs_s[m_own] = 1'b1;
      if (e_l) begin
        inc[m_own] = 1;
        nxt_own    = -1;
      end
    end
    hs_mi   = MI_AXIS_TVALID && e_mrdy;
    set_err = hs_mi && !tid_ok;
    if (hs_mi && MI_AXIS_TLAST && tid_ok) dec[tid] = 1;

    @(posedge ACLK);
    if (m_own >= 0 && nxt_own < 0) m_last = m_own;
    m_own = nxt_own;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = m_cnt[i] + inc[i] - dec[i];
      if (m_cnt[i] < 0) m_cnt[i] = 0;
      if (m_cnt[i] > int'(MAXO)) m_cnt[i] = int'(MAXO);
    end
    if (set_err) m_err = 1'b1;
    #1;
  endtask

  // Retire handshaked beats, present queue heads, and randomize in random mode.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hs_s[i]) begin
        S_AXIS_TVALID[i] = 1'b0;
        srcq[i].delete(0);
        hs_s[i] = 1'b0;
      end
      if (rnd && srcq[i].size() == 0 && !S_AXIS_TVALID[i] && $urandom_range(0, 2) == 0)
        push_pkt(i, int'($urandom_range(1, 4)));
      if (!S_AXIS_TVALID[i] && srcq[i].size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        S_AXIS_TDATA[i*BW +: BW] = srcq[i][0].data;
        S_AXIS_TLAST[i]          = srcq[i][0].last;
        S_AXIS_TUSER[i]          = srcq[i][0].user;
        S_AXIS_TVALID[i]         = 1'b1;
      end
    end
    if (hs_mi) begin
      MI_AXIS_TVALID = 1'b0;
      hs_mi = 1'b0;
    end
    if (rnd) begin
      MD_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      R_AXIS_TREADY  = N'($urandom);
      if (!MI_AXIS_TVALID && $urandom_range(0, 2) == 0) begin
        MI_AXIS_TVALID = 1'b1;
        MI_AXIS_TDATA  = $urandom;
        MI_AXIS_TLAST  = 1'($urandom);
        MI_AXIS_TID    = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(255, N))
                                                      : 8'($urandom_range(N - 1, 0));
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      drive();
    end
  endtask

  // Asynchronous reset: outputs must clear at once, release away from the clock edge.
  task automatic reset_dut();
    ARESETN = 1'b0;
    #1;
    check_eq("rst_md_valid", MD_AXIS_TVALID, 1'b0);
    check_eq("rst_s_ready", S_AXIS_TREADY, '0);
    check_eq("rst_err", ERR_BAD_TID, 1'b0);
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      hs_s[i] = 1'b0;
    end
    S_AXIS_TVALID = '0; S_AXIS_TLAST = '0; S_AXIS_TUSER = '0; S_AXIS_TDATA = '0;
    MD_AXIS_TREADY = 1'b0; R_AXIS_TREADY = '0;
    MI_AXIS_TVALID = 1'b0; MI_AXIS_TLAST = 1'b0; MI_AXIS_TID = '0; MI_AXIS_TDATA = '0;
    hs_mi = 1'b0;
    model_reset();
    tid_log.delete(); tlast_cyc.delete(); hs_cyc.delete();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int b0, c0;
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    ARESETN = 1'b1;
    S_AXIS_TVALID = '0; S_AXIS_TLAST = '0; S_AXIS_TUSER = '0; S_AXIS_TDATA = '0;
    MD_AXIS_TREADY = 1'b0; R_AXIS_TREADY = '0;
    MI_AXIS_TVALID = 1'b0; MI_AXIS_TLAST = 1'b0; MI_AXIS_TID = '0; MI_AXIS_TDATA = '0;
    hs_mi = 1'b0;
    for (int i = 0; i < N; i++) hs_s[i] = 1'b0;
    model_reset();
    #2;
    reset_dut();

    // Round-robin across all four requesters, 2-beat packets.
    for (int i = 0; i < N; i++) push_pkt(i, 2);
    push_pkt(0, 2);
    MD_AXIS_TREADY = 1'b1;
    drive();
    run(16);
    check_eq("rr_count", tid_log.size(), 5);
    for (int k = 0; k < 5 && k < tid_log.size(); k++) check_eq("rr_order", tid_log[k], exp_rr[k]);
    for (int k = 1; k < tlast_cyc.size(); k++) check_eq("rr_spacing", tlast_cyc[k] - tlast_cyc[k-1], 3);

    // Single requester, 3-beat packet, then its result.
    reset_dut();
    push_beat(0, {8'd1, 8'd2}, 1'b0);
    push_beat(0, {8'd3, 8'd4}, 1'b0);
    push_beat(0, {8'd5, 8'd6}, 1'b1);
    MD_AXIS_TREADY = 1'b1;
    drive();
    b0 = dut_beats; c0 = cyc;
    run(5);
    check_eq("t1_beats", dut_beats - b0, 3);
    if (hs_cyc.size() >= 3) begin
      check_eq("t1_first_beat", hs_cyc[0] - c0, 2);
      check_eq("t1_last_beat", hs_cyc[2] - c0, 4);
    end
    MI_AXIS_TVALID = 1'b1; MI_AXIS_TDATA = 32'd44; MI_AXIS_TLAST = 1'b1; MI_AXIS_TID = 8'd0;
    R_AXIS_TREADY = 4'b0001;
    #1;
    check_eq("t1_rvalid", R_AXIS_TVALID, 4'b0001);
    check_eq("t1_rdata", R_AXIS_TDATA, 32'd44);
    run(2);

    // Outstanding limit on requester 1.
    reset_dut();
    for (int k = 0; k < 3; k++) push_pkt(1, 2);
    MD_AXIS_TREADY = 1'b1;
    R_AXIS_TREADY  = '1;
    drive();
    b0 = dut_beats;
    run(12);
    check_eq("lim_beats", dut_beats - b0, 4);
    check_eq("lim_stall_rdy", S_AXIS_TREADY, '0);
    check_eq("lim_stall_vld", S_AXIS_TVALID[1], 1'b1);
    MI_AXIS_TVALID = 1'b1; MI_AXIS_TDATA = 32'h55; MI_AXIS_TLAST = 1'b1; MI_AXIS_TID = 8'd1;
    run(1);
    run(6);
    check_eq("lim_resume", dut_beats - b0, 6);

    // Backpressure: MAC ready toggles mid-packet.
    reset_dut();
    push_pkt(3, 4);
    drive();
    b0 = dut_beats;
    for (int k = 0; k < 12; k++) begin
      MD_AXIS_TREADY = (k % 2 == 0);
      step();
      drive();
    end
    check_eq("bp_beats", dut_beats - b0, 4);

    // Bad TID is swallowed and latches the error.
    MI_AXIS_TVALID = 1'b1; MI_AXIS_TDATA = 32'hDEAD; MI_AXIS_TLAST = 1'b1; MI_AXIS_TID = 8'd7;
    R_AXIS_TREADY = '0;
    #1;
    check_eq("bad_mi_ready", MI_AXIS_TREADY, 1'b1);
    check_eq("bad_rvalid", R_AXIS_TVALID, '0);
    run(4);
    check_eq("bad_sticky", ERR_BAD_TID, 1'b1);

    // Reset in the middle of a packet on requester 2.
    push_pkt(2, 4);
    MD_AXIS_TREADY = 1'b1;
    drive();
    run(3);
    check_eq("mid_busy", MD_AXIS_TVALID, 1'b1);
    reset_dut();
    push_pkt(2, 2);
    push_pkt(0, 2);
    MD_AXIS_TREADY = 1'b1;
    drive();
    run(8);
    check_eq("post_rst_count", tid_log.size(), 2);
    if (tid_log.size() > 0) check_eq("post_rst_first", tid_log[0], 0);

    // Randomized traffic.
    reset_dut();
    rnd = 1'b1;
    drive();
    run(4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
